vmicro16_fetch: RTL and testbench

Instruction fetch stage for the vmicro16 core: owns the program counter, issues in-order word reads to instruction memory, and buffers returned instructions with their PC in a small prefetch FIFO. Feeds the decode stage through a valid/ready handshake. Accepts branch/jump redirects from execute, which flush the buffer and discard in-flight fetches.

---
 rtl/vmicro16_pkg.sv | 18 +
 rtl/vmicro16_fetch_fifo.sv | 52 +++++
 rtl/vmicro16_fetch.sv | 104 ++++++++++
 tb/tb_vmicro16_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmicro16_pkg.sv
// Shared constants and types for the vmicro16 fetch path.
package vmicro16_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/vmicro16_fetch_fifo.sv
// Prefetch buffer of {pc, instr} entries; head is read straight from the register array.
module vmicro16_fetch_fifo
    import vmicro16_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] count_q;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + PtrW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/vmicro16_fetch.sv
// Instruction fetch: PC generation, credit-limited imem requests, prefetch FIFO to decode,
// and redirect handling that drops responses still in flight.
module vmicro16_fetch #(
    parameter int unsigned ADDR_WIDTH = vmicro16_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = vmicro16_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = vmicro16_pkg::RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [DATA_WIDTH-1:0] dec_instr,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt
);
    import vmicro16_pkg::*;

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] DepthLimit = (CntW + 1)'(FIFO_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0]       outstanding_q, outstanding_d;
    logic [CntW-1:0]       drop_q, drop_d;
    logic                  req_pending_q, req_pending_d;
    logic [CntW-1:0]       fifo_count;
    logic                  credit_ok, req_fire, rsp_keep, pop;
    fetch_entry_t          push_entry, head;

    // Dropped responses still occupy credit until they arrive.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < DepthLimit;

    always_comb begin
        state_d = halt ? StHalt : StRun;

        // A presented but unaccepted request stays up even across a halt.
        imem_req_valid = !reset && !redirect_valid &&
                         (req_pending_q || (state_q == StRun && credit_ok));
        req_fire      = imem_req_valid && imem_req_ready;
        req_pending_d = imem_req_valid && !imem_req_ready;

        rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
        pop      = dec_valid && dec_ready;

        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
        fetch_pc_d    = req_fire ? fetch_pc_q + ADDR_WIDTH'(1) : fetch_pc_q;
        rsp_pc_d      = rsp_keep ? rsp_pc_q + ADDR_WIDTH'(1) : rsp_pc_q;
        drop_d        = (imem_rsp_valid && drop_q != '0) ? drop_q - CntW'(1) : drop_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_VECTOR;
            rsp_pc_q      <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
            req_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            req_pending_q <= req_pending_d;
        end
    end

    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    vmicro16_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rsp_keep),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (fifo_count)
    );

    assign imem_req_addr = fetch_pc_q;
    assign dec_valid     = (fifo_count != '0);
    assign dec_instr     = head.instr;
    assign dec_pc        = head.pc;

endmodule

// File: tb/tb_vmicro16_fetch.sv
// Directed bench for vmicro16_fetch with a fixed-latency instruction memory model.
module tb_vmicro16_fetch;

    logic        clk = 1'b0;
    logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [15:0] imem_req_addr, imem_rsp_data, dec_instr, dec_pc, redirect_pc;
    logic        dec_valid, dec_ready, redirect_valid, halt;

    vmicro16_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] addr; int due;} mreq_t;
    typedef struct {logic [15:0] addr; int cyc;} req_t;
    typedef struct {logic [15:0] pc; logic [15:0] instr; int cyc;} pop_t;

    mreq_t mq[$];
    req_t  reqq[$];
    pop_t  popq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;

    logic        t_reset = 1'b1, t_dec_ready = 1'b1, t_redirect = 1'b0;
    logic        t_halt = 1'b0, t_req_ready = 1'b1;
    logic [15:0] t_redirect_pc = 16'h0000;

    localparam logic [15:0] Key = 16'hA5A5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: apply inputs at the falling edge, then record handshakes once settled.
    task automatic step();
        mreq_t m;
        @(negedge clk);
        cyc++;
        reset          = t_reset;
        dec_ready      = t_dec_ready;
        redirect_valid = t_redirect;
        redirect_pc    = t_redirect_pc;
        halt           = t_halt;
        imem_req_ready = t_req_ready;
        if (t_reset) mq.delete();
        if (!t_reset && mq.size() > 0 && mq[0].due == cyc) begin
            m              = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr ^ Key;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0000;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            reqq.push_back('{imem_req_addr, cyc});
            mq.push_back('{imem_req_addr, cyc + lat});
        end
        if (dec_valid && dec_ready) popq.push_back('{dec_pc, dec_instr, cyc});
    endtask

    task automatic apply_reset();
        t_reset = 1'b1;
        step();
        step();
        t_reset = 1'b0;
        reqq.delete();
        popq.delete();
    endtask

    // Out-of-range reads return a sentinel no 16-bit field can equal.
    function automatic logic [31:0] pop_field(input int i, input int f);
        if (i >= popq.size()) return 32'hDEAD_BEEF;
        case (f)
            0:       return {16'h0, popq[i].pc};
            1:       return {16'h0, popq[i].instr};
            default: return popq[i].cyc;
        endcase
    endfunction

    initial begin
        int r0, hc, first_new;
        reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;

        // Reset values and a 1-cycle memory streaming one instruction per cycle.
        lat = 1;
        t_reset = 1'b1;
        step();
        step();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 16'h0000);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_dec_instr", dec_instr, 0);
        check("rst_dec_pc", dec_pc, 0);
        t_reset = 1'b0;
        reqq.delete();
        popq.delete();
        step();
        r0 = cyc;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, 16'h0000);
        repeat (9) step();
        for (int i = 0; i < 6; i++) begin
            check("stream_pc", pop_field(i, 0), i);
            check("stream_instr", pop_field(i, 1), i ^ Key);
            check("stream_cyc", pop_field(i, 2), r0 + 2 + i);
        end

        // Decode stalled: credits cap issue at FIFO_DEPTH, then drain in order.
        apply_reset();
        t_dec_ready = 1'b0;
        repeat (20) step();
        check("stall_req_count", reqq.size(), 4);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_dec_valid", dec_valid, 1);
        t_dec_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 8; i++) check("stall_drain_pc", pop_field(i, 0), i);

        // 3-cycle memory, redirect to 0x0040 with two requests in flight.
        lat = 3;
        apply_reset();
        step();
        step();
        t_redirect = 1'b1;
        t_redirect_pc = 16'h0040;
        step();
        r0 = cyc;
        check("redir_req_withdrawn", imem_req_valid, 0);
        t_redirect = 1'b0;
        popq.delete();
        step();
        check("redir_next_valid", imem_req_valid, 1);
        check("redir_next_addr", imem_req_addr, 16'h0040);
        check("redir_dec_empty", dec_valid, 0);
        repeat (10) step();
        check("redir_pc0", pop_field(0, 0), 16'h0040);
        check("redir_instr0", pop_field(0, 1), 16'h0040 ^ Key);
        check("redir_cyc0", pop_field(0, 2), r0 + 5);
        check("redir_pc1", pop_field(1, 0), 16'h0041);

        // Address wrap after a redirect to 0xFFFE (in-flight response discarded).
        lat = 1;
        apply_reset();
        repeat (3) step();
        t_redirect = 1'b1;
        t_redirect_pc = 16'hFFFE;
        step();
        t_redirect = 1'b0;
        popq.delete();
        repeat (8) step();
        check("wrap_pc0", pop_field(0, 0), 16'hFFFE);
        check("wrap_pc1", pop_field(1, 0), 16'hFFFF);
        check("wrap_pc2", pop_field(2, 0), 16'h0000);
        check("wrap_instr2", pop_field(2, 1), 16'h0000 ^ Key);

        // Halt mid-stream: no issue, buffer drains, resume at next sequential PC.
        apply_reset();
        repeat (5) step();
        t_halt = 1'b1;
        step();
        hc = cyc;
        repeat (7) step();
        first_new = -1;
        for (int i = 0; i < reqq.size(); i++) begin
            if (reqq[i].cyc > hc && first_new < 0) first_new = i;
        end
        check("halt_no_issue", first_new, -1);
        check("halt_drained", dec_valid, 0);
        t_halt = 1'b0;
        repeat (8) step();
        first_new = -1;
        for (int i = 0; i < reqq.size(); i++) begin
            if (reqq[i].cyc > hc && first_new < 0) first_new = i;
        end
        check("halt_resume_addr", (first_new < 0) ? 32'hDEAD_BEEF : reqq[first_new].addr, 16'h0006);
        for (int i = 0; i < popq.size(); i++) check("halt_seq_pc", pop_field(i, 0), i);

        // Reset with a partly full buffer and two responses still owed.
        lat = 3;
        apply_reset();
        t_dec_ready = 1'b0;
        repeat (6) step();
        check("prereset_dec_valid", dec_valid, 1);
        check("prereset_req_count", reqq.size(), 4);
        t_reset = 1'b1;
        step();
        step();
        check("rst2_req_valid", imem_req_valid, 0);
        check("rst2_req_addr", imem_req_addr, 16'h0000);
        check("rst2_dec_valid", dec_valid, 0);
        check("rst2_dec_instr", dec_instr, 0);
        check("rst2_dec_pc", dec_pc, 0);
        t_reset = 1'b0;
        t_dec_ready = 1'b1;
        reqq.delete();
        popq.delete();
        repeat (10) step();
        check("rst2_pc0", pop_field(0, 0), 16'h0000);
        check("rst2_instr0", pop_field(0, 1), 16'h0000 ^ Key);
        check("rst2_pc1", pop_field(1, 0), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
